// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CNTMAX+1 clk cycles, publishes with freq_vld.
// Latency: result valid one cycle after the terminal gate cycle; sig_in edges counted 2 clk after s1 capture.
// Backpressure: none, freq_vld is a fire-and-forget strobe. Optional FREQ_METER_OVF_EN adds saturation + ovf.
module freq_meter #(
    parameter int unsigned GATE_CNTMAX = 49_999_999,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             freq_vld,
    output logic             busy,
    output logic             ovf
);

    localparam logic [31:0] GATE_MAX = 32'(GATE_CNTMAX);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [31:0]      gate_cnt_q;
    logic [31:0]      gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] edge_cnt_d;
    logic [CNT_W-1:0] edge_sum;
    logic [CNT_W-1:0] edge_inc;
    logic [CNT_W-1:0] freq_d;
    logic             freq_vld_d;
    logic             terminal;
    logic             publish;

    // s1/s2 resynchronise sig_in; s3 holds the previous synced level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign edge_sum = edge_cnt_q + CNT_W'(rise);
    // >= so a corrupted gate_cnt still closes the window instead of running away
    assign terminal = (gate_cnt_q >= GATE_MAX);
    assign publish  = (state_q == MEASURE) && terminal;
    assign busy     = (state_q == MEASURE);

`ifdef FREQ_METER_OVF_EN
    logic carry;
    logic sat_q;
    logic ovf_q;

    assign carry    = (&edge_cnt_q) & rise;
    assign edge_inc = carry ? {CNT_W{1'b1}} : edge_sum;
    assign ovf      = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (publish) begin
            ovf_q <= sat_q | carry;
            sat_q <= 1'b0;
        end else if ((state_q == MEASURE) && en) begin
            sat_q <= sat_q | carry;
        end else begin
            sat_q <= 1'b0;
        end
    end
`else
    assign edge_inc = edge_sum;
    assign ovf      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        freq_d     = freq;
        freq_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (en) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (terminal) begin
                    // terminal cycle's own edge belongs to this window
                    freq_d     = edge_inc;
                    freq_vld_d = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    state_d    = en ? MEASURE : IDLE;
                end else if (!en) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + 32'd1;
                    edge_cnt_d = edge_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq       <= '0;
            freq_vld   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq       <= freq_d;
            freq_vld   <= freq_vld_d;
        end
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter for the display path. It counts rising edges of an asynchronous input over a fixed window of `clk` cycles and publishes the count with a one-cycle valid strobe. This is the measuring counterpart to the clock dividers: the divider produces slow clocks, and this block measures them (or any external tone) so the tube can show the result. It runs continuously while enabled.

## Interface
- `GATE_CNTMAX`, default 49_999_999: the gate window lasts `GATE_CNTMAX+1` `clk` cycles (1 s at 50 MHz).
- `CNT_W`, default 32: width of the edge counter and of `freq`.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `en`  in  1  level; 1 runs back-to-back gate windows, 0 stops and aborts.
- `freq`  out  CNT_W  rising edges counted in the last completed window; holds between updates.
- `freq_vld`  out  1  one-cycle pulse when `freq` updates.
- `busy`  out  1  1 while a window is in progress (state MEASURE).
- `ovf`  out  1  overflow flag, updated together with `freq` (see Configuration).

## Operation
- Input conditioning: two-flop synchronizer `s1`→`s2`, then history flop `s3`. `rise = s2 & ~s3`.
- Counters:
  - `gate_cnt` is 32 bits and runs 0..GATE_CNTMAX.
  - `edge_cnt` is CNT_W bits.
- States:
  - IDLE: counters held at 0, `busy`=0. Move to MEASURE on the next edge when `en`=1.
  - MEASURE: each cycle, `gate_cnt`++ and `edge_cnt` += `rise`.
    - Terminal cycle (`gate_cnt`==GATE_CNTMAX):
      - `freq` <= `edge_cnt` + `rise`, so the terminal cycle's edge is included.
      - `freq_vld` <= 1; both counters <= 0.
      - Stay in MEASURE if `en`=1, else go to IDLE.
    - There are no dead cycles between consecutive windows.
  - Abort: `en`=0 in any non-terminal MEASURE cycle → IDLE next edge, counters cleared, no `freq_vld`, `freq`/`ovf` unchanged.
- Arithmetic: `gate_cnt` compares with `>=`, so any stray value over GATE_CNTMAX is treated as terminal.

## Timing
- Reset values: `freq`=0, `freq_vld`=0, `busy`=0, `ovf`=0, state IDLE, `s1`/`s2`/`s3`=0, all counters 0.
- Edge latency: a high `sig_in` first sampled by `s1` at edge k is counted at edge k+2.
- Input bandwidth: pulses shorter than one `clk` period may be missed. The maximum countable rate is `clk`/2.
- Start: `en` rises before edge n → `busy`=1 after edge n. The first `freq_vld` asserts after edge n+GATE_CNTMAX+1 and lasts exactly one cycle.
- Continuous operation: while `en` stays 1, `freq_vld` repeats every GATE_CNTMAX+1 cycles.
- `en` dropping in the terminal cycle: the result is still published, then the block goes to IDLE.
- Reset mid-window: everything returns to reset values immediately. There is no partial publish.

## Configuration
- Macro `FREQ_METER_OVF_EN`.
- Defined: `edge_cnt` saturates at all-ones. `ovf` <= 1 on publish if saturation occurred in that window, otherwise 0.
- Undefined: `edge_cnt` wraps modulo 2^CNT_W and `ovf` is tied to 0.

## Test plan
- Basic count: GATE_CNTMAX=99, `sig_in` square wave with period 10 `clk`, `en`=1 → `freq`=10 on each `freq_vld`; `freq_vld` pulses 100 cycles apart, each 1 cycle wide.
- Static input: `sig_in` held at 0, then at 1, for a full window → `freq`=0 both times; `freq_vld` still pulses.
- Abort: `en` drops at cycle 50 of a 100-cycle window → no `freq_vld`, `freq` keeps its prior value, `busy`=0 next cycle; re-enabling starts a fresh 100-cycle window.
- Overflow: CNT_W=4, GATE_CNTMAX=99, `sig_in` period 4 (25 edges per window) → with the macro, `freq`=15 and `ovf`=1; without it, `freq`=9 and `ovf`=0.
- Reset mid-window: assert `rst_n`=0 at cycle 60 → all outputs 0 at once; after release with `en`=1, the first `freq_vld` arrives 100 cycles later with a correct count.
- Terminal-cycle edge: place a `sig_in` rise so it is counted exactly in the terminal cycle → that edge appears in this window's `freq`, not the next one.
